// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The digit counter needs at least one bit, even when there is only one digit.
  function automatic int cnt_width(input int num_digits);
    int w;
    w = $clog2(num_digits);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// DIGIT-bit combinational ripple-carry slice built from per-bit full adders.
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout = c[DIGIT];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor pushing DIGIT bits per clock through one
// carry-chain slice, with a start/ready/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; ready=1
//   RUN   | one digit per cycle, LSB digit first; ready=0
//   DONE  | one-cycle done pulse; ready=1, start here chains the next operation
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int            NUM_DIGITS = WIDTH / DIGIT;
  localparam int            CW         = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0] LAST       = CW'(NUM_DIGITS - 1);

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic                   c_out_q, c_out_d;
  logic                   ovf_q, ovf_d;
  logic [DIGIT-1:0]       slice_s;
  logic                   slice_cout;
  logic [WIDTH+DIGIT-1:0] res_cat;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after the last shift.
  assign res_cat = {slice_s, res_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          count_d = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = slice_cout;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
          sum_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
          c_out_d = slice_cout;
          // The slice operands still hold the MSB digits of A and B' here.
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice_s[DIGIT-1] != a_q[DIGIT-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT = 1, 4, 16) at WIDTH=16,
// checked against an integer-arithmetic reference model.
module tb_digit_serial_adder;

  logic        clk;
  logic        reset;
  logic        sub;
  logic [15:0] a, b;
  logic        st1, st4, st16;

  logic        rdy1, dn1, co1, ov1;
  logic        rdy4, dn4, co4, ov4;
  logic        rdy16, dn16, co16, ov16;
  logic [15:0] sm1, sm4, sm16;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 4;

  logic        rdy_m, dn_m, co_m, ov_m;
  logic [15:0] sm_m;

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(st1), .sub(sub), .a(a), .b(b),
    .ready(rdy1), .done(dn1), .sum(sm1), .c_out(co1), .ovf(ov1));

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .start(st4), .sub(sub), .a(a), .b(b),
    .ready(rdy4), .done(dn4), .sum(sm4), .c_out(co4), .ovf(ov4));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .sub(sub), .a(a), .b(b),
    .ready(rdy16), .done(dn16), .sum(sm16), .c_out(co16), .ovf(ov16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1:  begin rdy_m = rdy1;  dn_m = dn1;  sm_m = sm1;  co_m = co1;  ov_m = ov1;  end
      16: begin rdy_m = rdy16; dn_m = dn16; sm_m = sm16; co_m = co16; ov_m = ov16; end
      default: begin rdy_m = rdy4; dn_m = dn4; sm_m = sm4; co_m = co4; ov_m = ov4; end
    endcase
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned wrap for sum, unsigned compare for carry, signed range for overflow.
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                output logic [15:0] r, output logic c, output logic o);
    int ux, uy, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = s ? (sx - sy) : (sx + sy);
    r  = s ? (x - y) : (x + y);
    c  = s ? (ux >= uy) : ((ux + uy) > 65535);
    o  = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic set_start(input logic v);
    st1  = (sel == 1)  ? v : 1'b0;
    st4  = (sel == 4)  ? v : 1'b0;
    st16 = (sel == 16) ? v : 1'b0;
  endtask

  // Issues one operation on the selected instance from IDLE and returns in its DONE cycle.
  // lat counts edges after the accepting edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                        output int lat, output int rdy_bad);
    @(negedge clk);
    a = ia; b = ib; sub = isub;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    lat = -1;
    rdy_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (dn_m) begin
        lat = k;
        break;
      end
      if (rdy_m) rdy_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? 1 : (i == 1) ? 4 : 16;
      #0;
      n_checks++;
      if ({rdy_m, dn_m, co_m, ov_m, sm_m} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
        n_fail++;
        $display("FAIL reset_state digit=%0d: got ready=%b done=%b sum=%h c=%b ovf=%b, required 1 0 0000 0 0",
                 sel, rdy_m, dn_m, sm_m, co_m, ov_m);
      end
    end
    sel = 4;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, rb;
    sel = 4;
    run_op(16'h1234, 16'h4321, 1'b0, lat, rb);
    n_checks++;
    if (lat !== 4 || rb !== 0) begin
      n_fail++;
      $display("FAIL basic_latency: got done after %0d edges, ready-high-in-run %0d, required 4 and 0", lat, rb);
    end
    n_checks++;
    if ({sm_m, co_m, ov_m} !== {16'h5555, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_add: got sum=%h c=%b ovf=%b, required 5555 0 0", sm_m, co_m, ov_m);
    end
  endtask

  task automatic test_carry_ovf();
    logic [15:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb_ [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] er [4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat, rb;
    sel = 4;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb_[i], ts[i], lat, rb);
      n_checks++;
      if (lat !== 4 || {sm_m, co_m, ov_m} !== {er[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL carry_ovf[%0d] %h %s %h: got lat=%0d sum=%h c=%b ovf=%b, required lat=4 sum=%h c=%b ovf=%b",
                 i, ta[i], ts[i] ? "-" : "+", tb_[i], lat, sm_m, co_m, ov_m, er[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    sel = 4;
    @(negedge clk);
    a = 16'h1000; b = 16'h0234; sub = 1'b0;
    set_start(1'b1);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    @(negedge clk);
    @(negedge clk);
    set_start(1'b0);
    lat = -1;
    for (int k = 2; k < 40; k++) begin
      if (dn_m) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (lat !== 4 || {sm_m, co_m, ov_m} !== {16'h1234, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL start_in_run: got lat=%0d sum=%h c=%b ovf=%b, required lat=4 sum=1234 c=0 ovf=0",
               lat, sm_m, co_m, ov_m);
    end
    @(negedge clk);
    n_checks++;
    if (dn_m !== 1'b0 || rdy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_run_after: got done=%b ready=%b, required done=0 ready=1", dn_m, rdy_m);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rb, held_bad;
    sel = 4;
    run_op(16'h1111, 16'h2222, 1'b0, lat, rb);
    n_checks++;
    if (lat !== 4 || sm_m !== 16'h3333) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d sum=%h, required lat=4 sum=3333", lat, sm_m);
    end
    a = 16'h0010; b = 16'h0020; sub = 1'b0;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    a = 16'hAAAA; b = 16'h5555;
    lat = -1;
    held_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (dn_m) begin
        lat = k;
        break;
      end
      if (sm_m !== 16'h3333) held_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (lat !== 4 || held_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_timing: got second done %0d cycles after first, %0d cycles with sum not held, required 5 and 0",
               lat + 1, held_bad);
    end
    n_checks++;
    if ({sm_m, co_m, ov_m} !== {16'h0030, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got sum=%h c=%b ovf=%b, required 0030 0 0", sm_m, co_m, ov_m);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, rb, spurious;
    sel = 4;
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; sub = 1'b0;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({rdy_m, dn_m, sm_m, co_m, ov_m} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_op: got ready=%b done=%b sum=%h c=%b ovf=%b, required 1 0 0000 0 0",
               rdy_m, dn_m, sm_m, co_m, ov_m);
    end
    spurious = 0;
    for (int k = 0; k < 8; k++) begin
      if (dn_m) spurious++;
      @(negedge clk);
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done cycles after abort, required 0", spurious);
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat, rb);
    n_checks++;
    if (lat !== 4 || sm_m !== 16'h0002) begin
      n_fail++;
      $display("FAIL reset_fresh_op: got lat=%0d sum=%h, required lat=4 sum=0002", lat, sm_m);
    end
  endtask

  task automatic test_param_sweep();
    int lat, rb;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 1 : 16;
      run_op(16'hABCD, 16'h1111, 1'b0, lat, rb);
      n_checks++;
      if (lat !== (16 / sel) || rb !== 0 || {sm_m, co_m, ov_m} !== {16'hBCDE, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL sweep_digit%0d: got lat=%0d ready-in-run=%0d sum=%h c=%b ovf=%b, required lat=%0d 0 BCDE 0 0",
                 sel, lat, rb, sm_m, co_m, ov_m, 16 / sel);
      end
    end
    sel = 4;
  endtask

  task automatic test_random();
    logic [15:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [15:0] ra, rb_, er;
    logic        rs, ec, eo;
    int lat, rdb;
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? 1 : (i == 1) ? 4 : 16;
      for (int n = 0; n < 1000; n++) begin
        ra  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
        rb_ = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
        rs  = 1'($urandom_range(0, 1));
        model(ra, rb_, rs, er, ec, eo);
        run_op(ra, rb_, rs, lat, rdb);
        n_checks++;
        if (lat !== (16 / sel) || rdb !== 0 || {sm_m, co_m, ov_m} !== {er, ec, eo}) begin
          n_fail++;
          $display("FAIL random digit=%0d %h %s %h: got lat=%0d sum=%h c=%b ovf=%b, required lat=%0d sum=%h c=%b ovf=%b",
                   sel, ra, rs ? "-" : "+", rb_, lat, sm_m, co_m, ov_m, 16 / sel, er, ec, eo);
        end
      end
    end
    sel = 4;
  endtask

  initial begin
    reset = 1'b1;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    st1   = 1'b0;
    st4   = 1'b0;
    st16  = 1'b0;
    test_reset();
    test_basic();
    test_carry_ovf();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_param_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
